param_gpio_sequencer: RTL
=========================

# param_gpio_sequencer

Avalon-MM master that drives the 1-bit parameter GPIO port through its register map and serialises parameter words onto it. Each bit is presented on `out_port` and held until the remote end acknowledges it with a falling edge on `in_port`, which the GPIO reports through its edge-capture register and `irq`. The block sits between the parameter-comms command logic and the GPIO slave, and is the only master of that slave.

## Interface

**Parameters**
- `IDLE_LEVEL`, default 1: `out_port` level written after reset, after each command and on error.
- `TMO_W`, default 16: width of the acknowledge timeout counter.

**Ports**
- `clk` input 1: single clock.
- `reset_n` input 1: reset, synchronous, active-low.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: command accepted when `cmd_valid & cmd_ready` is high at a `clk` edge.
- `cmd_data` input 32: word to send, MSB-first, starting at bit `cmd_len-1`.
- `cmd_len` input 6: number of bits to send; the legal range is 1..32.
- `timeout_cycles` input TMO_W: acknowledge timeout per bit; 0 disables the timeout.
- `rsp_valid` output 1: one-cycle completion pulse. There is no backpressure.
- `rsp_error` output 1: qualified by `rsp_valid`. High for a timeout or an illegal length.
- `rsp_bits` output 6: qualified by `rsp_valid`. Number of bits acknowledged.
- `rsp_line` output 1: qualified by `rsp_valid`. `in_port` level read back at the end of the command.
- `busy` output 1: high in every state except IDLE.
- `m_address` output 3: GPIO register address.
- `m_chipselect` output 1: GPIO chip select.
- `m_write_n` output 1: GPIO write strobe, active-low.
- `m_writedata` output 32: GPIO write data.
- `m_readdata` input 32: GPIO read data, registered by the GPIO, valid 1 cycle after the address is presented.
- `gpio_irq` input 1: GPIO `irq` output.

## Operation

**GPIO register map used**
- 0: data; write sets `out_port`, read returns `in_port`.
- 2: `irq_mask`.
- 3: edge capture; any write clears it.

**Bus idle values.** `m_chipselect`=0, `m_write_n`=1, `m_address`=0, `m_writedata`=0. A write is one cycle with `m_chipselect`=1 and `m_write_n`=0. A read is one cycle with `m_address` driven and `m_chipselect`=0; the data is captured on the next cycle.

**States**
- INIT_MASK: write addr 2 = 1. Go to INIT_PARK.
- INIT_PARK: write addr 0 = IDLE_LEVEL. Go to IDLE.
- IDLE: `cmd_ready`=1.
  - Legal accept: latch `cmd_data`, `cmd_len` and `timeout_cycles`, clear the bit count, go to CLR0.
  - `cmd_len` of 0 or greater than 32: go to DONE with `rsp_error`=1 and `rsp_bits`=0. There is no bus activity.
- CLR0: write addr 3, which clears any stale edge. Go to DRIVE.
- DRIVE: write addr 0 = current bit, zero-extended. Load the timeout counter. Go to WAIT.
- WAIT: no bus access.
  - `gpio_irq`=1: go to CLR.
  - `gpio_irq`=0 and the timeout counter reaches 0, with timeout enabled: go to PARK with the error flag set.
  - Otherwise decrement the counter.
- CLR: write addr 3 and increment the bit count.
  - If the count equals the latched length: go to PARK.
  - Otherwise go to DRIVE with the next lower bit.
- PARK: write addr 0 = IDLE_LEVEL. Go to SAMPLE_A.
- SAMPLE_A: read addr 0. Go to SAMPLE_C.
- SAMPLE_C: `rsp_line` ← `m_readdata[0]`. Go to DONE.
- DONE: `rsp_valid`=1 for one cycle. Go to IDLE.

**Counting and boundaries**
- The timeout counter is TMO_W bits wide. It counts down from the latched `timeout_cycles` and saturates at 0.
- `rsp_bits` equals the number of completed CLR states. On a timeout it is the index of the failed bit.
- The command inputs are ignored outside IDLE, and `cmd_ready`=0 during INIT_MASK and INIT_PARK.
- `gpio_irq` is ignored outside WAIT.
- An `irq` that is still high on entry to WAIT, from a stale edge, is prevented by CLR0 and CLR. Those clears take effect in the GPIO on the cycle after the write.

**Reset** (`reset_n`=0 at a `clk` edge, including mid-command)
- State goes to INIT_MASK and the bus returns to idle values.
- `rsp_valid`=0, `rsp_error`=0, `rsp_bits`=0, `rsp_line`=0, `cmd_ready`=0, `busy`=1.
- The aborted command produces no response.

## Timing

- After reset release:
  - cycle 1: INIT_MASK write
  - cycle 2: INIT_PARK write
  - cycle 3: IDLE, with `cmd_ready`=1
- Per bit: DRIVE (1) + WAIT (k ≥ 1) + CLR (1) cycles, where k is the number of WAIT cycles up to and including the first cycle in which `gpio_irq`=1.
- Accept-to-`rsp_valid`: 1 (CLR0) + Σ(2+kᵢ) + 3 (PARK, SAMPLE_A, SAMPLE_C), with `rsp_valid` in the following cycle. For N=1 and k=1, `rsp_valid` is high in the 8th cycle after the accept edge.
- A timeout on bit i with T=`timeout_cycles`: WAIT lasts T cycles, then PARK.
- Illegal length: `rsp_valid` is high in the 1st cycle after the accept edge.
- A new command can be accepted in the cycle after DONE.

## Test plan

- **Single bit.** `cmd_data`=0x1, `cmd_len`=1; `gpio_irq` high 1 cycle after DRIVE.
  - Writes, in order: a3, a0=1, a3, a0=IDLE_LEVEL, then a read of a0.
  - `rsp_valid` 8 cycles after accept, `rsp_error`=0, `rsp_bits`=1.
- **Full word.** `cmd_data`=0xA5A5_0F0F, `cmd_len`=32; the GPIO model acknowledges each bit after 3 cycles.
  - The a0 write sequence matches bits 31 down to 0.
  - `rsp_bits`=32, and the total latency is 1 + 32·5 + 3 + 1 = 165 cycles.
- **Timeout.** `timeout_cycles`=10, `cmd_len`=8; no acknowledge on the 3rd bit.
  - WAIT lasts 10 cycles, then PARK writes IDLE_LEVEL.
  - `rsp_error`=1, `rsp_bits`=2.
- **Illegal length.** `cmd_len`=0, then `cmd_len`=40.
  - Each gives `rsp_valid` with `rsp_error`=1 and `rsp_bits`=0 one cycle after accept.
  - No `m_chipselect` activity.
- **Reset mid-command.** Assert `reset_n`=0 for 1 cycle during the WAIT of bit 5.
  - Bus returns to idle values, no `rsp_valid`.
  - INIT_MASK and INIT_PARK writes are reissued, then `cmd_ready`=1 at cycle 3.
- **Readback and stale edge.** The model holds `in_port`=0 at the end of the command and asserts `gpio_irq` before the command starts.
  - The stale `irq` is cleared by CLR0, and DRIVE still waits for a fresh acknowledge.
  - `rsp_line`=0.

Source files
------------

// File: rtl/param_gpio_sequencer.sv
// param_gpio_sequencer
//
// Avalon-MM master for the 1-bit parameter GPIO. It sends a parameter word
// MSB-first, one bit at a time. Each bit is written to the GPIO data
// register. The block then waits for the remote end to acknowledge the bit
// with a falling edge on in_port, which the GPIO reports through edge capture
// and irq. When the command ends, the line is parked at IDLE_LEVEL, in_port is
// read back, and a one-cycle response is issued.
//
// Ports
//   clk, reset_n          single clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (accepted only in IDLE)
//   cmd_data, cmd_len     word and bit count (1..32, MSB at bit cmd_len-1)
//   timeout_cycles        per-bit acknowledge timeout, 0 = wait forever
//   rsp_valid             one-cycle completion pulse, no backpressure
//   rsp_error/bits/line   timeout-or-bad-length flag, bits acknowledged,
//                         in_port level read back at the end
//   busy                  high whenever not IDLE
//   m_address, m_chipselect, m_write_n, m_writedata, m_readdata
//                         GPIO slave port (registered bus outputs)
//   gpio_irq              GPIO irq output (edge capture & mask)
module param_gpio_sequencer #(
  parameter logic IDLE_LEVEL = 1'b1,
  parameter int   TMO_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_data,
  input  logic [5:0]       cmd_len,
  input  logic [TMO_W-1:0] timeout_cycles,
  output logic             rsp_valid,
  output logic             rsp_error,
  output logic [5:0]       rsp_bits,
  output logic             rsp_line,
  output logic             busy,
  output logic [2:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [31:0]      m_writedata,
  input  logic [31:0]      m_readdata,
  input  logic             gpio_irq
);

  localparam logic [2:0]       ADDR_DATA = 3'd0;
  localparam logic [2:0]       ADDR_MASK = 3'd2;
  localparam logic [2:0]       ADDR_EDGE = 3'd3;
  localparam logic [TMO_W-1:0] TMO_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_INIT_MASK, S_INIT_PARK, S_IDLE, S_CLR0, S_DRIVE, S_WAIT,
    S_CLR, S_PARK, S_SAMPLE_A, S_SAMPLE_C, S_DONE
  } state_t;

  state_t           state_reg;
  logic [31:0]      shift_reg;     // word left-aligned so the current bit is always [31]
  logic [5:0]       len_reg;
  logic [5:0]       bit_cnt_reg;
  logic [TMO_W-1:0] tmo_lim_reg;
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             err_reg;

  logic [2:0]       addr_reg;
  logic             cs_reg;
  logic             wr_n_reg;
  logic [31:0]      wdata_reg;
  logic             rsp_valid_reg;
  logic             rsp_error_reg;
  logic [5:0]       rsp_bits_reg;
  logic             rsp_line_reg;

  logic             len_ok;
  logic [5:0]       align_sh;
  logic [5:0]       bit_cnt_inc;
  logic             unused_rdata;

  assign len_ok       = (cmd_len != 6'd0) && (cmd_len <= 6'd32);
  assign align_sh     = 6'd32 - cmd_len;
  assign bit_cnt_inc  = bit_cnt_reg + 6'd1;
  assign unused_rdata = ^m_readdata[31:1];

  // Bus and response outputs are registered on entry to the state that owns
  // them. As a result, a write is visible during the cycle the FSM spends in
  // that state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= S_INIT_MASK;
      shift_reg     <= '0;
      len_reg       <= '0;
      bit_cnt_reg   <= '0;
      tmo_lim_reg   <= '0;
      tmo_cnt_reg   <= '0;
      err_reg       <= 1'b0;
      addr_reg      <= ADDR_DATA;
      cs_reg        <= 1'b0;
      wr_n_reg      <= 1'b1;
      wdata_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_error_reg <= 1'b0;
      rsp_bits_reg  <= '0;
      rsp_line_reg  <= 1'b0;
    end else begin
      // Bus idles unless the next state issues an access.
      addr_reg      <= ADDR_DATA;
      cs_reg        <= 1'b0;
      wr_n_reg      <= 1'b1;
      wdata_reg     <= '0;
      rsp_valid_reg <= 1'b0;

      case (state_reg)
        // INIT_MASK spans two cycles. The first one after reset has an idle
        // bus. The second presents the mask write. cs_reg tells the two apart.
        S_INIT_MASK: begin
          cs_reg   <= 1'b1;
          wr_n_reg <= 1'b0;
          if (!cs_reg) begin
            addr_reg  <= ADDR_MASK;
            wdata_reg <= 32'd1;
          end else begin
            addr_reg  <= ADDR_DATA;
            wdata_reg <= {31'd0, IDLE_LEVEL};
            state_reg <= S_INIT_PARK;
          end
        end

        S_INIT_PARK: state_reg <= S_IDLE;

        S_IDLE: begin
          if (cmd_valid) begin
            if (len_ok) begin
              shift_reg   <= cmd_data << align_sh;
              len_reg     <= cmd_len;
              tmo_lim_reg <= timeout_cycles;
              bit_cnt_reg <= '0;
              err_reg     <= 1'b0;
              addr_reg    <= ADDR_EDGE;
              cs_reg      <= 1'b1;
              wr_n_reg    <= 1'b0;
              wdata_reg   <= 32'd1;
              state_reg   <= S_CLR0;
            end else begin
              rsp_valid_reg <= 1'b1;
              rsp_error_reg <= 1'b1;
              rsp_bits_reg  <= '0;
              state_reg     <= S_DONE;
            end
          end
        end

        S_CLR0: begin
          cs_reg    <= 1'b1;
          wr_n_reg  <= 1'b0;
          wdata_reg <= {31'd0, shift_reg[31]};
          state_reg <= S_DRIVE;
        end

        S_DRIVE: begin
          tmo_cnt_reg <= tmo_lim_reg;
          state_reg   <= S_WAIT;
        end

        // Acknowledge wins over an expiring timeout in the same cycle. The
        // check against 1 makes WAIT last exactly timeout_cycles cycles.
        S_WAIT: begin
          if (gpio_irq) begin
            addr_reg  <= ADDR_EDGE;
            cs_reg    <= 1'b1;
            wr_n_reg  <= 1'b0;
            wdata_reg <= 32'd1;
            state_reg <= S_CLR;
          end else if ((tmo_lim_reg != '0) && (tmo_cnt_reg <= TMO_ONE)) begin
            err_reg   <= 1'b1;
            cs_reg    <= 1'b1;
            wr_n_reg  <= 1'b0;
            wdata_reg <= {31'd0, IDLE_LEVEL};
            state_reg <= S_PARK;
          end else if (tmo_cnt_reg != '0) begin
            tmo_cnt_reg <= tmo_cnt_reg - TMO_ONE;
          end
        end

        S_CLR: begin
          bit_cnt_reg <= bit_cnt_inc;
          shift_reg   <= shift_reg << 1;
          cs_reg      <= 1'b1;
          wr_n_reg    <= 1'b0;
          if (bit_cnt_inc == len_reg) begin
            wdata_reg <= {31'd0, IDLE_LEVEL};
            state_reg <= S_PARK;
          end else begin
            // The shift lands at this same edge, so the next bit is still at [30].
            wdata_reg <= {31'd0, shift_reg[30]};
            state_reg <= S_DRIVE;
          end
        end

        // The read is an address-0 cycle with chipselect low. The GPIO returns
        // registered data during SAMPLE_C.
        S_PARK: begin
          addr_reg  <= ADDR_DATA;
          state_reg <= S_SAMPLE_A;
        end

        S_SAMPLE_A: state_reg <= S_SAMPLE_C;

        S_SAMPLE_C: begin
          rsp_line_reg  <= m_readdata[0];
          rsp_valid_reg <= 1'b1;
          rsp_error_reg <= err_reg;
          rsp_bits_reg  <= bit_cnt_reg;
          state_reg     <= S_DONE;
        end

        S_DONE: state_reg <= S_IDLE;

        default: state_reg <= S_INIT_MASK;
      endcase
    end
  end

  assign cmd_ready    = (state_reg == S_IDLE);
  assign busy         = (state_reg != S_IDLE);
  assign m_address    = addr_reg;
  assign m_chipselect = cs_reg;
  assign m_write_n    = wr_n_reg;
  assign m_writedata  = wdata_reg;
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_error    = rsp_error_reg;
  assign rsp_bits     = rsp_bits_reg;
  assign rsp_line     = rsp_line_reg;

endmodule
